// File: rtl/trace_sched_if.sv
// Tracer handshake and trace-buffer write port of trace_sched.
// master = scheduler side, slave = tracer / buffer side.
interface trace_sched_if;
    logic       trc_start;
    logic [9:0] trc_column;
    logic       trc_done;
    logic       trc_side;
    logic [7:0] trc_height;
    logic [9:0] buf_addr;
    logic       buf_we;
    logic       buf_side;
    logic [7:0] buf_height;

    modport master (
        output trc_start, trc_column, buf_addr, buf_we, buf_side, buf_height,
        input  trc_done, trc_side, trc_height
    );
    modport slave (
        input  trc_start, trc_column, buf_addr, buf_we, buf_side, buf_height,
        output trc_done, trc_side, trc_height
    );
endinterface

// File: rtl/trace_sched.sv
// Per-frame column trace scheduler: issues one tracer request per column during vblank and
// drains results into the trace buffer around render reads. Option: TRACE_OVERRUN_COUNT_EN.
module trace_sched #(
    parameter int SCREEN_WIDTH = 640,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vblank,
    input  logic          visible,
    input  logic [9:0]    h,
    trace_sched_if.master bus,
    output logic          frame_done,
    output logic          overrun
`ifdef TRACE_OVERRUN_COUNT_EN
    ,
    output logic [7:0]    overrun_count
`endif
);
    localparam int              PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              CW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [9:0]      LAST_COL = 10'(SCREEN_WIDTH - 1);
    localparam logic [PW-1:0]   LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, WAIT, DRAIN, DONE} state_t;
    state_t r_state, w_state_nxt;

    logic          r_vblank_d;
    logic [9:0]    r_col;
    logic          r_trc_start;
    logic          r_buf_we;
    logic          r_buf_side;
    logic [7:0]    r_buf_height;
    logic [9:0]    r_wr_col;
    logic          r_frame_done;
    logic          r_overrun;

    logic [9:0]    r_fifo_col  [FIFO_DEPTH];
    logic          r_fifo_side [FIFO_DEPTH];
    logic [7:0]    r_fifo_ht   [FIFO_DEPTH];
    logic [PW-1:0] r_rd_ptr, r_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_rise, w_fall, w_empty, w_full;
    logic w_start, w_push, w_pop, w_abort, w_load, w_col_inc, w_set_done;

    assign w_rise  = vblank & ~r_vblank_d;
    assign w_fall  = ~vblank & r_vblank_d;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    // visible is sampled here; the write it permits is presented in the following cycle
    assign w_pop   = ~w_empty & ~visible & ~w_abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_push      = 1'b0;
        w_abort     = 1'b0;
        w_load      = 1'b0;
        w_col_inc   = 1'b0;
        w_set_done  = 1'b0;
        if (w_fall && (r_state == START || r_state == WAIT || r_state == DRAIN)) begin
            w_abort     = 1'b1;
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: if (w_rise) begin
                    w_load      = 1'b1;
                    w_state_nxt = START;
                end
                START: if (!w_full) begin
                    w_start     = 1'b1;
                    w_state_nxt = WAIT;
                end
                WAIT: if (bus.trc_done) begin
                    w_push = 1'b1;
                    if (r_col == LAST_COL) begin
                        w_state_nxt = DRAIN;
                    end else begin
                        w_col_inc   = 1'b1;
                        w_state_nxt = START;
                    end
                end
                DRAIN: if (w_empty) begin
                    w_set_done  = 1'b1;
                    w_state_nxt = DONE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // held high so a reset released mid-vblank is not mistaken for a rising edge
            r_vblank_d   <= 1'b1;
            r_col        <= '0;
            r_trc_start  <= 1'b0;
            r_buf_we     <= 1'b0;
            r_buf_side   <= 1'b0;
            r_buf_height <= '0;
            r_wr_col     <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
        end else begin
            r_vblank_d  <= vblank;
            r_trc_start <= w_start;
            r_buf_we    <= w_pop;
            if (w_pop) begin
                r_wr_col     <= r_fifo_col[r_rd_ptr];
                r_buf_side   <= r_fifo_side[r_rd_ptr];
                r_buf_height <= r_fifo_ht[r_rd_ptr];
                r_rd_ptr     <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
            end
            if (w_push)
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
            if (w_abort) begin
                r_rd_ptr  <= '0;
                r_wr_ptr  <= '0;
                r_count   <= '0;
                r_overrun <= 1'b1;
            end else if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (w_load) begin
                r_col        <= '0;
                r_frame_done <= 1'b0;
                r_overrun    <= 1'b0;
            end else if (w_col_inc) begin
                r_col <= r_col + 10'd1;
            end
            if (w_set_done) r_frame_done <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_col[r_wr_ptr]  <= r_col;
            r_fifo_side[r_wr_ptr] <= bus.trc_side;
            r_fifo_ht[r_wr_ptr]   <= bus.trc_height;
        end
    end

`ifdef TRACE_OVERRUN_COUNT_EN
    logic [7:0] r_ovr_cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                             r_ovr_cnt <= '0;
        else if (w_abort && r_ovr_cnt != 8'hFF) r_ovr_cnt <= r_ovr_cnt + 8'd1;
    end
    assign overrun_count = r_ovr_cnt;
`endif

    // render reads own the address bus; otherwise show the write in flight, then the head
    always_comb begin
        bus.buf_addr = r_col;
        if (visible)       bus.buf_addr = h;
        else if (r_buf_we) bus.buf_addr = r_wr_col;
        else if (!w_empty) bus.buf_addr = r_fifo_col[r_rd_ptr];
    end

    assign bus.trc_start  = r_trc_start;
    assign bus.trc_column = r_col;
    assign bus.buf_we     = r_buf_we;
    assign bus.buf_side   = r_buf_side;
    assign bus.buf_height = r_buf_height;
    assign frame_done     = r_frame_done;
    assign overrun        = r_overrun;
endmodule

// File: tb/tb_trace_sched.sv
// Directed bench for trace_sched: cycle vector table, async reset, full frame, abort,
// and (with TRACE_OVERRUN_COUNT_EN) overrun counter saturation.
module tb_trace_sched;
    logic       clk = 1'b0;
    logic       reset, vblank, visible;
    logic [9:0] h;
    logic       frame_done, overrun;
`ifdef TRACE_OVERRUN_COUNT_EN
    logic [7:0] overrun_count;
`endif

    trace_sched_if tif();

    trace_sched dut (
        .clk        (clk),
        .reset      (reset),
        .vblank     (vblank),
        .visible    (visible),
        .h          (h),
        .bus        (tif),
        .frame_done (frame_done),
        .overrun    (overrun)
`ifdef TRACE_OVERRUN_COUNT_EN
        ,
        .overrun_count (overrun_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vb, vis;
        logic [9:0] hh;
        logic       dn, s;
        logic [7:0] ht;
        logic       e_ts;
        logic [9:0] e_col;
        logic       e_we;
        logic [9:0] e_addr;
        logic       e_s;
        logic [7:0] e_ht;
        logic       e_ov;
    } vec_t;

    vec_t tbl[$];
    int   n_chk = 0, n_err = 0;
    int   trc_cnt, exp_addr, order_err, max_col, first_bad, n;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input int vb, vis, hh, dn, s, ht, ets, ecol, ewe, eaddr, es, eht, eov);
        vec_t v;
        v.vb = 1'(vb);  v.vis = 1'(vis); v.hh = 10'(hh); v.dn = 1'(dn); v.s = 1'(s);
        v.ht = 8'(ht);  v.e_ts = 1'(ets); v.e_col = 10'(ecol); v.e_we = 1'(ewe);
        v.e_addr = 10'(eaddr); v.e_s = 1'(es); v.e_ht = 8'(eht); v.e_ov = 1'(eov);
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one cycle of a tracer that answers 3 cycles after trc_start with height=column[7:0]
    task automatic trace_cycle();
        tick();
        if (tif.buf_we) begin
            if (tif.buf_addr !== 10'(exp_addr) || tif.buf_height !== exp_addr[7:0] ||
                tif.buf_side !== exp_addr[0]) begin
                if (order_err == 0) first_bad = exp_addr;
                order_err++;
            end
            exp_addr++;
        end
        if (int'(tif.trc_column) > max_col) max_col = int'(tif.trc_column);
        tif.trc_done = 1'b0;
        if (trc_cnt > 0) begin
            trc_cnt--;
            if (trc_cnt == 0) begin
                tif.trc_done   = 1'b1;
                tif.trc_height = tif.trc_column[7:0];
                tif.trc_side   = tif.trc_column[0];
            end
        end
        if (tif.trc_start) trc_cnt = 3;
    endtask

    task automatic chk_outs(input string nm, input logic ts, input logic [9:0] col,
                            input logic we, input logic [9:0] addr, input logic ov);
        chk({nm, ".trc_start"},  32'(tif.trc_start),  32'(ts));
        chk({nm, ".trc_column"}, 32'(tif.trc_column), 32'(col));
        chk({nm, ".buf_we"},     32'(tif.buf_we),     32'(we));
        chk({nm, ".buf_addr"},   32'(tif.buf_addr),   32'(addr));
        chk({nm, ".overrun"},    32'(overrun),        32'(ov));
    endtask

    initial begin
        //  vb vis  h  dn s  ht     ts col we addr s  ht    ov
        add(1, 0,   0, 0, 0, 0,     0, 0,  0, 0,   0, 0,    0);
        add(1, 0,   0, 0, 0, 0,     1, 0,  0, 0,   0, 0,    0);
        add(1, 0,   0, 1, 1, 'hAA,  0, 1,  0, 0,   0, 0,    0);
        add(1, 1, 100, 0, 0, 0,     1, 1,  0, 100, 0, 0,    0);
        add(1, 1, 100, 1, 0, 'h55,  0, 2,  0, 100, 0, 0,    0);
        add(1, 1,   7, 0, 0, 0,     0, 2,  0, 7,   0, 0,    0);
        add(1, 1,   7, 0, 0, 0,     0, 2,  0, 7,   0, 0,    0);
        add(1, 0,   7, 0, 0, 0,     0, 2,  1, 0,   1, 'hAA, 0);
        add(1, 0,   7, 0, 0, 0,     1, 2,  1, 1,   0, 'h55, 0);
        add(1, 0,   7, 0, 0, 0,     0, 2,  0, 2,   0, 'h55, 0);
        add(1, 0,   7, 1, 1, 'h02,  0, 3,  0, 2,   0, 'h55, 0);
        add(1, 0,   7, 0, 0, 0,     1, 3,  1, 2,   1, 'h02, 0);
        add(1, 1,  50, 1, 0, 'h03,  0, 4,  0, 50,  1, 'h02, 0);
        add(1, 1,  50, 0, 0, 0,     1, 4,  0, 50,  1, 'h02, 0);
        add(1, 0,  50, 1, 1, 'h04,  0, 5,  1, 3,   0, 'h03, 0);
        add(1, 0,  50, 0, 0, 0,     1, 5,  1, 4,   1, 'h04, 0);
        add(1, 0,  50, 0, 0, 0,     0, 5,  0, 5,   1, 'h04, 0);
        add(1, 1,  50, 1, 0, 'h05,  0, 6,  0, 50,  1, 'h04, 0);
        add(0, 0,  50, 0, 0, 0,     0, 6,  0, 6,   1, 'h04, 1);
        add(0, 0,  50, 0, 0, 0,     0, 6,  0, 6,   1, 'h04, 1);
        add(1, 0,  50, 0, 0, 0,     0, 0,  0, 0,   1, 'h04, 0);
        add(1, 0,  50, 0, 0, 0,     1, 0,  0, 0,   1, 'h04, 0);

        reset = 1'b1; vblank = 1'b0; visible = 1'b0; h = '0;
        tif.trc_done = 1'b0; tif.trc_side = 1'b0; tif.trc_height = '0;
        #1 reset = 1'b0;
        #2;
        chk_outs("rst", 1'b0, 10'd0, 1'b0, 10'd0, 1'b0);
        chk("rst.frame_done", 32'(frame_done), 32'd0);
        chk("rst.buf_side",   32'(tif.buf_side), 32'd0);
        chk("rst.buf_height", 32'(tif.buf_height), 32'd0);
        #9 reset = 1'b1;
        tick();

        foreach (tbl[i]) begin
            vblank = tbl[i].vb; visible = tbl[i].vis; h = tbl[i].hh;
            tif.trc_done = tbl[i].dn; tif.trc_side = tbl[i].s; tif.trc_height = tbl[i].ht;
            tick();
            chk_outs($sformatf("v%0d", i), tbl[i].e_ts, tbl[i].e_col, tbl[i].e_we,
                     tbl[i].e_addr, tbl[i].e_ov);
            chk($sformatf("v%0d.buf_side", i),   32'(tif.buf_side),   32'(tbl[i].e_s));
            chk($sformatf("v%0d.buf_height", i), 32'(tif.buf_height), 32'(tbl[i].e_ht));
            chk($sformatf("v%0d.frame_done", i), 32'(frame_done),     32'd0);
        end
        tif.trc_done = 1'b0;

        // async reset while waiting on the tracer, then release mid-vblank
        #3 reset = 1'b0;
        #1;
        chk_outs("rst_wait", 1'b0, 10'd0, 1'b0, 10'd0, 1'b0);
        chk("rst_wait.buf_side",   32'(tif.buf_side),   32'd0);
        chk("rst_wait.buf_height", 32'(tif.buf_height), 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        n = 0;
        repeat (6) begin
            tick();
            if (tif.trc_start) n++;
        end
        chk("rst_mid_vblank.starts", 32'(n), 32'd0);
        chk("rst_mid_vblank.col",    32'(tif.trc_column), 32'd0);

        // full frame
        vblank = 1'b0;
        tick();
        vblank = 1'b1;
        trc_cnt = 0; exp_addr = 0; order_err = 0; max_col = 0; first_bad = -1;
        for (int c = 0; c < 8000 && frame_done !== 1'b1; c++) trace_cycle();
        chk("frame.frame_done", 32'(frame_done), 32'd1);
        chk("frame.writes",     32'(exp_addr),   32'd640);
        chk("frame.order_errs", 32'(order_err),  32'd0);
        if (order_err != 0) $display("  first out-of-order write at index %0d", first_bad);
        chk("frame.overrun",    32'(overrun),    32'd0);
        chk("frame.last_col",   32'(tif.trc_column), 32'd639);
        chk("frame.max_col",    32'(max_col),    32'd639);

        vblank = 1'b0;
        repeat (3) tick();
        chk("done.fd_held", 32'(frame_done), 32'd1);
        chk("done.overrun", 32'(overrun),    32'd0);
        vblank = 1'b1;
        tick();
        chk("restart.fd_clr", 32'(frame_done), 32'd0);
        chk("restart.col",    32'(tif.trc_column), 32'd0);

        // abort at column 300 with two results held back by the render path
        trc_cnt = 0; exp_addr = 0;
        for (int c = 0; c < 4000 && tif.trc_column != 10'd300; c++) begin
            trace_cycle();
            if (tif.trc_column >= 10'd299) visible = 1'b1;
        end
        chk("abort.reached_300", 32'(tif.trc_column), 32'd300);
        vblank = 1'b0; tif.trc_done = 1'b0; trc_cnt = 0;
        tick();
        chk_outs("abort", 1'b0, 10'd300, 1'b0, 10'(h), 1'b1);
        visible = 1'b0;
        n = 0;
        repeat (8) begin
            tick();
            if (tif.buf_we || tif.trc_start) n++;
        end
        chk("abort.no_activity", 32'(n), 32'd0);
        chk("abort.addr_empty",  32'(tif.buf_addr), 32'd300);
        chk("abort.overrun",     32'(overrun), 32'd1);
        vblank = 1'b1;
        tick();
        chk("abort_restart.col", 32'(tif.trc_column), 32'd0);
        chk("abort_restart.ov",  32'(overrun), 32'd0);
        tick();
        chk("abort_restart.ts",  32'(tif.trc_start), 32'd1);

`ifdef TRACE_OVERRUN_COUNT_EN
        chk("ovr_cnt.one", 32'(overrun_count), 32'd1);
        for (int k = 0; k < 260; k++) begin
            vblank = 1'b0;
            tick();
            vblank = 1'b1;
            tick();
        end
        chk("ovr_cnt.sat", 32'(overrun_count), 32'd255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
